load_store_unit: RTL and testbench

Multi-cycle load/store unit for the RV32I core. It accepts the effective address produced by the ALU for load (opcode 5'b00000) and store (opcode 5'b01000) instructions, together with func3 and the rs2 store data. It performs a request/grant/response transaction on the data-memory bus and returns a sign- or zero-extended load result. The core stalls while the unit is busy.

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit for an RV32I core.
// Takes a load/store instruction (opcode[6:2], func3, effective address,
// rs2 store data), runs one request/grant(/rvalid) transaction on the data
// bus and returns an extended load result with an error code.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake (ready only when idle)
//   opcode, func3, addr,     instruction fields latched on acceptance
//   store_data
//   resp_valid, load_data,   one-cycle completion pulse with result and
//   err                      error code (00 ok, 01 misaligned, 10 timeout,
//                            11 illegal)
//   busy                     core stall, high whenever not idle
//   mem_*                    data-memory bus (req/gnt, rvalid/rdata)
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic [1:0]  err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_t;

  state_t          state_q;
  logic            is_store_q;
  logic [2:0]      func3_q;
  logic [1:0]      offset_q;
  logic [CntW-1:0] cnt_q;

  // Request decode, evaluated on the incoming (not yet latched) fields.
  logic        is_load, is_store, legal, misaligned;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  always_comb begin
    is_load  = (opcode == OpLoad);
    is_store = (opcode == OpStore);
    legal    = (is_load  && (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
               (is_store && (func3 inside {3'b000, 3'b001, 3'b010}));
    // func3[1:0] encodes the access width for every legal combination.
    misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    unique case (func3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << addr[1:0];
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Lane selection and extension of the returned read word.
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  always_comb begin
    unique case (offset_q)
      2'b00:   byte_lane = mem_rdata[7:0];
      2'b01:   byte_lane = mem_rdata[15:8];
      2'b10:   byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (func3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      func3_q    <= 3'b000;
      offset_q   <= 2'b00;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      load_data  <= 32'h0;
      err        <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            is_store_q <= is_store;
            func3_q    <= func3;
            offset_q   <= addr[1:0];
            mem_addr   <= {addr[31:2], 2'b00};
            if (!legal || misaligned) begin
              err        <= legal ? 2'b01 : 2'b11;
              load_data  <= 32'h0;
              resp_valid <= 1'b1;
              state_q    <= StDone;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_wstrb <= is_store ? wstrb : 4'b0000;
              mem_wdata <= is_store ? wdata : 32'h0;
              cnt_q     <= '0;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          // A grant in the final counted cycle wins over the timeout.
          if (mem_gnt || (cnt_q == CntMax)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
          end
          if (mem_gnt) begin
            if (is_store_q) begin
              err        <= 2'b00;
              load_data  <= 32'h0;
              resp_valid <= 1'b1;
              state_q    <= StDone;
            end else begin
              cnt_q   <= '0;
              state_q <= StWaitR;
            end
          end else if (cnt_q == CntMax) begin
            err        <= 2'b10;
            load_data  <= 32'h0;
            resp_valid <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitR: begin
          if (mem_rvalid) begin
            err        <= 2'b00;
            load_data  <= load_ext;
            resp_valid <= 1'b1;
            state_q    <= StDone;
          end else if (cnt_q == CntMax) begin
            err        <= 2'b10;
            load_data  <= 32'h0;
            resp_valid <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus tasks push expected
// responses (data, err, completion cycle); a monitor pops and compares on
// every resp_valid.
module tb_load_store_unit;

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic [1:0]  err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .err        (err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, ".load_data"}, load_data, e.data);
          check({e.name, ".err"}, {30'h0, err}, {30'h0, e.err});
          check({e.name, ".cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle; returns its acceptance cycle.
  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, output int t0);
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    opcode     = op;
    func3      = f3;
    addr       = a;
    store_data = sd;
    t0         = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push(input string name, input logic [31:0] d, input logic [1:0] e, input int c);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.cyc  = c;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    int t0;
    issue(OpLoad, f3, a, 32'h0, t0);
    push(name, exp, 2'b00, t0 + 3);
    check({name, ".mem_req"}, {31'h0, mem_req}, 32'h1);
    check({name, ".mem_we"}, {31'h0, mem_we}, 32'h0);
    check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
    // rvalid with garbage alongside the grant must be ignored.
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    step();
    mem_gnt   = 1'b0;
    mem_rdata = rdata;
    check({name, ".mem_req_wait"}, {31'h0, mem_req}, 32'h0);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [3:0] strb,
                          input logic [31:0] wd, input int delay);
    int t0;
    issue(OpStore, f3, a, sd, t0);
    push(name, 32'h0, 2'b00, t0 + 2 + delay);
    for (int i = 0; i <= delay; i++) begin
      check({name, ".mem_req"}, {31'h0, mem_req}, 32'h1);
      check({name, ".mem_we"}, {31'h0, mem_we}, 32'h1);
      check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
      check({name, ".mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, strb});
      check({name, ".mem_wdata"}, mem_wdata, wd);
      if (i == delay) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
  endtask

  task automatic do_error(input string name, input logic [4:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] e);
    int t0;
    issue(op, f3, a, 32'hFFFFFFFF, t0);
    push(name, 32'h0, e, t0 + 1);
    check({name, ".mem_req"}, {31'h0, mem_req}, 32'h0);
    step();
    check({name, ".mem_req_after"}, {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    int t0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    opcode     = 5'h0;
    func3      = 3'h0;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    step();
    step();
    rst = 1'b0;

    check("rst.req_ready", {31'h0, req_ready}, 32'h1);
    check("rst.busy", {31'h0, busy}, 32'h0);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.err", {30'h0, err}, 32'h0);
    check("rst.load_data", load_data, 32'h0);
    check("rst.mem_req", {31'h0, mem_req}, 32'h0);
    check("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);

    do_load("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb", 3'b000, 32'h103, 32'h80FF1234, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF1234, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102, 32'h80FF1234, 32'h000080FF);
    do_load("lh", 3'b001, 32'h102, 32'h80FF1234, 32'hFFFF80FF);
    do_load("lb0", 3'b000, 32'h100, 32'h80FF1234, 32'h00000034);

    do_store("sb", 3'b000, 32'h201, 32'h000000AB, 4'b0010, 32'hABABABAB, 0);
    do_store("sh", 3'b001, 32'h202, 32'h1234CDEF, 4'b1100, 32'hCDEFCDEF, 2);
    do_store("sw", 3'b010, 32'h204, 32'h12345678, 4'b1111, 32'h12345678, 1);

    do_error("sw_mis", OpStore, 3'b010, 32'h202, 2'b01);
    do_error("lh_mis", OpLoad, 3'b001, 32'h101, 2'b01);
    do_error("bad_op", 5'b01100, 3'b000, 32'h0, 2'b11);
    do_error("lw_f3", OpLoad, 3'b011, 32'h100, 2'b11);
    do_error("st_f3", OpStore, 3'b100, 32'h100, 2'b11);

    // Timeout: four REQ cycles with no grant.
    issue(OpLoad, 3'b001, 32'h10, 32'h0, t0);
    push("timeout", 32'h0, 2'b10, t0 + 5);
    for (int i = 0; i < 4; i++) begin
      check("timeout.mem_req", {31'h0, mem_req}, 32'h1);
      step();
    end
    check("timeout.mem_req_drop", {31'h0, mem_req}, 32'h0);
    do_load("lw_after_to", 3'b010, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D);

    // Reset while waiting for read data, with rvalid in the same cycle.
    issue(OpLoad, 3'b010, 32'h100, 32'h0, t0);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b0;
    check("midrst.req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst.busy", {31'h0, busy}, 32'h0);
    check("midrst.mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst.resp_valid", {31'h0, resp_valid}, 32'h0);
    step();
    step();
    do_store("sw_after_rst", 3'b010, 32'h400, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5, 0);

    step();
    step();
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
